// File: rtl/jacaranda_flash_loader.sv
// Boot loader for jacaranda-8: reads an image from SPI flash with READ (0x03),
// writes it into instruction memory, then releases the core from reset.
module jacaranda_flash_loader #(
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter int          LENGTH     = 256,
  parameter int          IMEM_AW    = 8,
  parameter int          SCK_DIV    = 2,
  parameter int          AUTOBOOT   = 1
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               cpu_rst_n,
  output logic               flash_csb,
  output logic               flash_clk,
  output logic               flash_io0,
  input  logic               flash_io1,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [7:0]         imem_wdata
);

  localparam int             DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [31:0]    CMD_WORD  = {8'h03, START_ADDR};
  localparam logic [IMEM_AW:0] LAST_BYTE = (IMEM_AW+1)'(LENGTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_FINISH, S_DONE} state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic               first_clk;
  logic [31:0]        cmd_sr;
  logic [4:0]         cmd_cnt;
  logic [2:0]         bit_cnt;
  logic [IMEM_AW:0]   byte_idx;
  logic [6:0]         rx_sr;
  logic               div_wrap, sck_rise, sck_fall, load_go, active;

  // A (re)load starts from IDLE (autoboot on the first clock after reset, or a
  // start pulse that is not coincident with reset release) or from DONE.
  always_comb begin
    active     = (state == S_CMD) || (state == S_DATA) || (state == S_FINISH);
    div_wrap   = (div_cnt == DIV_W'(SCK_DIV - 1));
    sck_rise   = div_wrap && !flash_clk && ((state == S_CMD) || (state == S_DATA));
    sck_fall   = div_wrap && flash_clk;
    load_go    = ((state == S_IDLE) &&
                  (((AUTOBOOT != 0) && first_clk) || (start && !first_clk))) ||
                 ((state == S_DONE) && start);
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (load_go) state_next = S_CMD;
      S_CMD:    if (sck_rise && (cmd_cnt == 5'd31)) state_next = S_DATA;
      S_DATA:   if (sck_rise && (bit_cnt == 3'd7) && (byte_idx == LAST_BYTE))
                  state_next = S_FINISH;
      S_FINISH: if (div_wrap && !flash_clk) state_next = S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      first_clk  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_rst_n  <= 1'b0;
      flash_csb  <= 1'b1;
      flash_clk  <= 1'b0;
      flash_io0  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      div_cnt    <= '0;
      cmd_sr     <= '0;
      cmd_cnt    <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      rx_sr      <= '0;
    end else begin
      first_clk <= 1'b0;
      imem_we   <= 1'b0;
      if (load_go) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        cpu_rst_n <= 1'b0;
        flash_csb <= 1'b0;
        flash_clk <= 1'b0;
        flash_io0 <= CMD_WORD[31];
        cmd_sr    <= {CMD_WORD[30:0], 1'b0};
        div_cnt   <= '0;
        cmd_cnt   <= '0;
        bit_cnt   <= '0;
        byte_idx  <= '0;
      end else if (active) begin
        div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
        if (sck_rise) begin
          flash_clk <= 1'b1;
          if (state == S_CMD) begin
            cmd_cnt <= cmd_cnt + 5'd1;
          end else begin
            rx_sr   <= {rx_sr[5:0], flash_io1};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              imem_we    <= 1'b1;
              imem_addr  <= byte_idx[IMEM_AW-1:0];
              imem_wdata <= {rx_sr, flash_io1};
              byte_idx   <= byte_idx + 1'b1;
            end
          end
        end
        // MOSI only moves on falling SCK; zeros once the command is out.
        if (sck_fall) begin
          flash_clk <= 1'b0;
          if (state == S_CMD) begin
            flash_io0 <= cmd_sr[31];
            cmd_sr    <= {cmd_sr[30:0], 1'b0};
          end else begin
            flash_io0 <= 1'b0;
          end
        end
        if ((state == S_FINISH) && div_wrap && !flash_clk) begin
          flash_csb <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b1;
          cpu_rst_n <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jacaranda_flash_loader.sv
// Bench for jacaranda_flash_loader: three loader instances with different
// parameters, a behavioural SPI flash per instance and a write scoreboard.
module tb_jacaranda_flash_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] rstn, start, io1;
  logic [2:0] csb, sck, io0, we, busy, done, cpu;
  logic [1:0] addr0;
  logic [7:0] addr1, addr2, wd0, wd1, wd2;

  logic [2:0] p_csb, p_sck, p_io0, p_we, p_done;
  int         run [3];
  int         rises [3];
  logic [31:0] cmdw [3];
  logic [17:0] exp_q[$];
  int total, bad;

  jacaranda_flash_loader #(.START_ADDR(24'h000000), .LENGTH(4), .IMEM_AW(2),
    .SCK_DIV(2), .AUTOBOOT(1)) dut_a (
    .clock(clock), .resetb(rstn[0]), .start(start[0]), .busy(busy[0]),
    .done(done[0]), .cpu_rst_n(cpu[0]), .flash_csb(csb[0]), .flash_clk(sck[0]),
    .flash_io0(io0[0]), .flash_io1(io1[0]), .imem_we(we[0]),
    .imem_addr(addr0), .imem_wdata(wd0));

  jacaranda_flash_loader #(.START_ADDR(24'h000100), .LENGTH(2), .IMEM_AW(8),
    .SCK_DIV(3), .AUTOBOOT(0)) dut_b (
    .clock(clock), .resetb(rstn[1]), .start(start[1]), .busy(busy[1]),
    .done(done[1]), .cpu_rst_n(cpu[1]), .flash_csb(csb[1]), .flash_clk(sck[1]),
    .flash_io0(io0[1]), .flash_io1(io1[1]), .imem_we(we[1]),
    .imem_addr(addr1), .imem_wdata(wd1));

  jacaranda_flash_loader #(.START_ADDR(24'h000000), .LENGTH(4), .IMEM_AW(8),
    .SCK_DIV(1), .AUTOBOOT(1)) dut_c (
    .clock(clock), .resetb(rstn[2]), .start(start[2]), .busy(busy[2]),
    .done(done[2]), .cpu_rst_n(cpu[2]), .flash_csb(csb[2]), .flash_clk(sck[2]),
    .flash_io0(io0[2]), .flash_io1(io1[2]), .imem_we(we[2]),
    .imem_addr(addr2), .imem_wdata(wd2));

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 1;
  endfunction

  function automatic int len_of(input int i);
    return (i == 1) ? 2 : 4;
  endfunction

  function automatic logic [23:0] start_of(input int i);
    return (i == 1) ? 24'h000100 : 24'h000000;
  endfunction

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'h11;
      24'h000001: return 8'h22;
      24'h000002: return 8'h33;
      24'h000003: return 8'h44;
      24'h000100: return 8'hA5;
      24'h000101: return 8'h5A;
      default:    return 8'hFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_load(input int i);
    for (int a = 0; a < len_of(i); a++)
      exp_q.push_back({2'(i), 8'(a), flash_byte(start_of(i) + 24'(a))});
  endtask

  // One system clock: sample at the falling edge, model the flash, score writes.
  task automatic step();
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      int k;
      logic [7:0] b, aw, wd;
      if (csb[i]) begin
        check("sck_idle_when_deselected", 32'(sck[i]), 0);
      end else begin
        if (p_csb[i]) begin
          run[i] = 1; rises[i] = 0; cmdw[i] = '0;
        end else if (sck[i] != p_sck[i]) begin
          check("sck_half_period", run[i], div_of(i));
          run[i] = 1;
        end else begin
          run[i]++;
        end
        if (sck[i] && !p_sck[i]) begin
          check("io0_stable_at_rise", 32'(io0[i]), 32'(p_io0[i]));
          if (rises[i] < 32) cmdw[i] = {cmdw[i][30:0], io0[i]};
          else check("io0_zero_in_data", 32'(io0[i]), 0);
          rises[i]++;
          if (rises[i] == 32) check("cmd_word", cmdw[i], {8'h03, start_of(i)});
        end
        if (!sck[i] && p_sck[i]) begin
          k = rises[i] - 32;
          if (k >= 0 && k < 8 * len_of(i)) begin
            b = flash_byte(cmdw[i][23:0] + 24'(k / 8));
            io1[i] = b[7 - (k % 8)];
          end
        end
      end
      if (we[i]) begin
        aw = (i == 0) ? {6'b0, addr0} : (i == 1) ? addr1 : addr2;
        wd = (i == 0) ? wd0 : (i == 1) ? wd1 : wd2;
        check("we_single_cycle", 32'(p_we[i]), 0);
        check("cpu_held_while_loading", 32'(cpu[i]), 0);
        check("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("imem_write", 32'({2'(i), aw, wd}), 32'(exp_q.pop_front()));
      end
      if (done[i] && !p_done[i]) begin
        check("sck_rise_count", rises[i], 32 + 8 * len_of(i));
        check("busy_low_at_done", 32'(busy[i]), 0);
        check("cpu_released_at_done", 32'(cpu[i]), 1);
      end
    end
    p_csb = csb; p_sck = sck; p_io0 = io0; p_we = we; p_done = done;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (!done[i] && n < 5000) begin step(); n++; end
    check("done_within_budget", 32'(done[i]), 1);
    check("cpu_rst_n_after_done", 32'(cpu[i]), 1);
    check("busy_after_done", 32'(busy[i]), 0);
    check("csb_after_done", 32'(csb[i]), 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    rstn = '0; start = '0; io1 = '0;
    p_csb = '1; p_sck = '0; p_io0 = '0; p_we = '0; p_done = '0;
    for (int i = 0; i < 3; i++) begin run[i] = 0; rises[i] = 0; cmdw[i] = '0; end
    repeat (3) step();

    for (int i = 0; i < 3; i++) begin
      check("rst_csb", 32'(csb[i]), 1);
      check("rst_sck", 32'(sck[i]), 0);
      check("rst_io0", 32'(io0[i]), 0);
      check("rst_we", 32'(we[i]), 0);
      check("rst_busy", 32'(busy[i]), 0);
      check("rst_done", 32'(done[i]), 0);
      check("rst_cpu", 32'(cpu[i]), 0);
    end
    check("rst_addr", 32'(addr0), 0);
    check("rst_wdata", 32'(wd0), 0);

    // Autoboot load of four bytes.
    push_load(0);
    rstn[0] = 1'b1;
    step();
    check("autoboot_busy", 32'(busy[0]), 1);
    check("autoboot_csb", 32'(csb[0]), 0);
    wait_done(0);

    // Reset pulse in the middle of byte 2, then a full restart.
    rstn[0] = 1'b0; step(); step();
    push_load(0);
    rstn[0] = 1'b1;
    n = 0;
    while (exp_q.size() > 2 && n < 2000) begin step(); n++; end
    check("two_bytes_before_abort", exp_q.size(), 2);
    repeat (6) step();
    #2 rstn[0] = 1'b0;
    #1;
    check("abort_csb", 32'(csb[0]), 1);
    check("abort_sck", 32'(sck[0]), 0);
    check("abort_cpu", 32'(cpu[0]), 0);
    check("abort_busy", 32'(busy[0]), 0);
    check("abort_we", 32'(we[0]), 0);
    exp_q.delete();
    repeat (10) step();
    push_load(0);
    rstn[0] = 1'b1;
    wait_done(0);

    // Manual-start instance: start coincident with reset release is ignored.
    rstn[1] = 1'b1; start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    repeat (20) step();
    check("idle_csb", 32'(csb[1]), 1);
    check("idle_busy", 32'(busy[1]), 0);
    check("idle_done", 32'(done[1]), 0);
    push_load(1);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    check("start_busy", 32'(busy[1]), 1);
    n = 0;
    while (exp_q.size() > 1 && n < 2000) begin step(); n++; end
    check("one_byte_before_restart_pulse", exp_q.size(), 1);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    wait_done(1);
    push_load(1);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    check("reload_cpu", 32'(cpu[1]), 0);
    check("reload_done", 32'(done[1]), 0);
    check("reload_busy", 32'(busy[1]), 1);
    wait_done(1);

    // Fastest SCK.
    push_load(2);
    rstn[2] = 1'b1;
    wait_done(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jacaranda_flash_loader.md
Name: jacaranda_flash_loader

Overview:
Boot sequencer for the jacaranda-8 core in the user area. After reset it holds the core in reset and reads a program image from the external SPI flash using the plain READ command (0x03). It writes each received byte into the core's instruction memory, then releases the core. It is the only master on its flash pins and is the sole writer of instruction memory while loading.

Parameters:
START_ADDR, 24'h000000, flash byte address of image byte 0
LENGTH, 256, image size in bytes; 1..2**IMEM_AW
IMEM_AW, 8, instruction memory address width
SCK_DIV, 2, system clocks per flash_clk half-period; >=1
AUTOBOOT, 1, 1 = start loading automatically after reset release

Ports:
clock  input  1  system clock
resetb  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; requests a (re)load
busy  output  1  high while a load is in progress
done  output  1  sticky; set when a load completes, cleared by a new load
cpu_rst_n  output  1  active-low reset to jacaranda-8; low until done
flash_csb  output  1  flash chip select, active low
flash_clk  output  1  SPI clock, mode 0
flash_io0  output  1  MOSI
flash_io1  input  1  MISO
imem_we  output  1  instruction memory write strobe, 1 cycle
imem_addr  output  IMEM_AW  write address = byte index
imem_wdata  output  8  write data

Behaviour:
- Reset (async, resetb=0): flash_csb=1, flash_clk=0, flash_io0=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, cpu_rst_n=0, FSM=IDLE. Assertion mid-load aborts immediately; no further writes occur.
- FSM states: IDLE -> CMD -> DATA -> FINISH -> DONE.
- IDLE: move to CMD on the first clock after reset release if AUTOBOOT=1; otherwise wait for start.
- Entering CMD: busy=1, done=0, cpu_rst_n=0, flash_csb=0. flash_io0 presents bit 31 of the command word {8'h03, START_ADDR} in the same cycle.
- SCK timing:
  - Divider counter runs from 0 to SCK_DIV-1; flash_clk toggles on wrap.
  - Each half-period is exactly SCK_DIV clocks.
  - flash_io0 changes only on flash_clk falling edges.
  - flash_io1 is sampled at the clock where flash_clk rises.
- CMD: 32 rising edges, MSB first. After the 32nd rising edge, go to DATA. flash_io0 is held 0 afterwards.
- DATA:
  - 8*LENGTH rising edges; bits are shifted MSB first into an 8-bit register.
  - One clock after the 8th sampling edge of byte i: imem_we=1 for exactly one clock, with imem_addr=i and imem_wdata=assembled byte.
  - imem_addr/imem_wdata hold their values between strobes.
  - Byte index is IMEM_AW+1 bits wide so LENGTH=2**IMEM_AW terminates without wrap.
- FINISH: after the last byte's write strobe, flash_clk stays low. flash_csb returns to 1 after SCK_DIV clocks, then go to DONE.
- DONE: busy=0, done=1, cpu_rst_n=1, all in the same cycle.
- start while busy is ignored.
- start in DONE: next clock cpu_rst_n=0, done=0, busy=1, FSM=CMD.
- start coincident with resetb release is ignored; AUTOBOOT governs.
- Total flash_clk rising edges per load = 32+8*LENGTH. There is no extra edge after the last data bit.

Test Plan:
1. AUTOBOOT=1, LENGTH=4, SCK_DIV=2, flash holds 11 22 33 44 at 0 -> io0 carries 0x03000000; writes (0,0x11) (1,0x22) (2,0x33) (3,0x44); done=1; cpu_rst_n=1; exactly 64 SCK rising edges.
2. START_ADDR=24'h000100, LENGTH=2, bytes A5 5A -> command word 0x03000100; writes (0,0xA5) (1,0x5A).
3. SCK_DIV=1 and SCK_DIV=3 -> flash_clk high/low widths of 1 and 3 clocks; flash_io0 stable at every rising edge; csb stays low through the last rising edge.
4. resetb pulsed low during byte 2 of the LENGTH=4 load -> flash_csb=1, flash_clk=0, cpu_rst_n=0 with no clock edge needed; no write to addr 2; after release, load restarts from addr 0 and completes correctly.
5. AUTOBOOT=0 -> idle with csb=1 and busy=0 until start. A start pulse mid-load -> no effect on edge count or writes. A start pulse after done -> cpu_rst_n falls the next clock, full reload, done re-asserts.
6. IMEM_AW=2, LENGTH=4 -> addresses 0..3 written once each, no wrap to 0, FSM ends in DONE.
